// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the pipelined RV32I core. Owns the program
// counter, presents the word address to the instruction memory and captures
// the returned instruction together with its PC in the IF/ID register.
//
// Per-edge priority: reset > halted > redirect > stall > flush > normal.
//
// Optional feature macro: FETCH_HALT_EN
//   Defined     - fetch stops (halted=1, PC frozen, bubbles issued) on a
//                 normal-capture edge whose PC word index is >= IMEM_DEPTH or
//                 whose fetched word is all zeros. Only reset clears it.
//   Not defined - halted is constant 0 and every word is captured.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32'd18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        halted
);

  // addi x0,x0,0 -- the instruction carried by a pipeline bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc_d;
  logic [31:0] id_instr_q;
  logic [31:0] id_instr_d;
  logic        id_valid_q;
  logic        id_valid_d;
  logic        halted_q;
  logic        halted_d;
  logic        halt_hit_s;

`ifdef FETCH_HALT_EN
  // Detect the end of the program: PC past the memory or an all-zero word.
  always_comb begin
    halt_hit_s = 1'b0;
    if (({2'b00, pc_q[31:2]} >= IMEM_DEPTH) || (imem_instr == 32'h0000_0000)) begin
      halt_hit_s = 1'b1;
    end else begin
      halt_hit_s = 1'b0;
    end
  end
`else
  // Without the halt feature fetch never stops on its own.
  assign halt_hit_s = 1'b0;
`endif

  // Next-state selection for the PC, the IF/ID register and the halt flag.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    halted_d   = halted_q;

    if (halted_q) begin
      // Frozen: everything holds until reset.
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
    end else if (redirect) begin
      // Wins over stall: whatever is stalled lies on the wrong path.
      pc_d       = redirect_target & 32'hFFFF_FFFC;
      id_pc_d    = 32'h0000_0000;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
      if (flush) begin
        id_pc_d    = 32'h0000_0000;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end else begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
      end
    end else if (flush) begin
      pc_d       = pc_q + 32'd4;
      id_pc_d    = 32'h0000_0000;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (halt_hit_s) begin
      // Do not capture the offending word; park the PC on it.
      pc_d       = pc_q;
      id_pc_d    = 32'h0000_0000;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      halted_d   = 1'b1;
    end else begin
      // Normal capture; PC wraps modulo 2^32.
      pc_d       = pc_q + 32'd4;
      id_pc_d    = pc_q;
      id_instr_d = imem_instr;
      id_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0000_0000;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      halted_q   <= halted_d;
    end
  end

  // The memory address depends only on the PC register, never on the controls.
  assign imem_addr = {2'b00, pc_q[31:2]};
  assign if_pc     = pc_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_valid  = id_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed scoreboard bench for fetch_stage. Each stimulus step pushes the
// hand-computed post-edge state; a monitor pops and compares on the falling
// edge. A second instance with RESET_PC=FFFF_FFFC covers PC wrap-around.
// Memory word i holds A000_0000+i (i<64); anything beyond reads 0BAD_0BAD.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        halted;

  logic [31:0] w_imem_addr;
  logic [31:0] w_if_pc;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_instr;
  logic        w_id_valid;
  logic        w_halted;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_HALT_EN
  // The wrap instance halts at once because FFFF_FFFC is past the memory.
  localparam logic [31:0] WRAP_NEXT = 32'hFFFF_FFFC;
`else
  localparam logic [31:0] WRAP_NEXT = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a < 32'd64) return 32'hA000_0000 + a;
    else return 32'h0BAD_0BAD;
  endfunction

  assign imem_instr = word_at(imem_addr);

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .if_pc(if_pc),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .halted(halted)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0),
    .redirect(1'b0), .redirect_target(32'h0000_0000),
    .imem_addr(w_imem_addr), .imem_instr(32'h0000_0113), .if_pc(w_if_pc),
    .id_pc(w_id_pc), .id_instr(w_id_instr), .id_valid(w_id_valid), .halted(w_halted)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] addr;
    logic        hlt;
    logic        chkw;
    logic [31:0] wpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  // Drive one cycle of controls and queue the state expected after the edge.
  task automatic step(input logic r, input logic s, input logic f, input logic rd,
                      input logic [31:0] tgt, input logic [31:0] e_pc,
                      input logic [31:0] e_instr, input logic e_valid,
                      input logic [31:0] e_addr, input logic e_hlt,
                      input logic e_chkw, input logic [31:0] e_wpc);
    exp_t e;
    reset = r; stall = s; flush = f; redirect = rd; redirect_target = tgt;
    @(posedge clk);
    #1;
    e.pc = e_pc; e.instr = e_instr; e.valid = e_valid; e.addr = e_addr;
    e.hlt = e_hlt; e.chkw = e_chkw; e.wpc = e_wpc;
    exp_q.push_back(e);
  endtask

  task automatic bubble(input logic r, input logic s, input logic f, input logic rd,
                        input logic [31:0] tgt, input logic [31:0] e_addr, input logic e_hlt);
    step(r, s, f, rd, tgt, 32'h0, NOP, 1'b0, e_addr, e_hlt, 1'b0, 32'h0);
  endtask

  task automatic normal(input logic [31:0] e_pc, input logic [31:0] e_addr);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e_pc, 32'hA000_0000 + (e_pc >> 2), 1'b1,
         e_addr, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("id_pc",     id_pc,           e.pc);
        chk("id_instr",  id_instr,        e.instr);
        chk("id_valid",  {31'h0, id_valid}, {31'h0, e.valid});
        chk("imem_addr", imem_addr,       e.addr);
        chk("if_pc",     if_pc,           {e.addr[29:0], 2'b00});
        chk("halted",    {31'h0, halted}, {31'h0, e.hlt});
        if (e.chkw) chk("wrap_if_pc", w_if_pc, e.wpc);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    // Straight-line fetch W0, W1
    normal(32'h0, 32'd1);
    normal(32'h4, 32'd2);
    // Stall three cycles at pc=8: IF/ID keeps W1, address stays 2
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4, 32'hA000_0001, 1'b1, 32'd2, 1'b0, 1'b0, 32'h0);
    normal(32'h8, 32'd3);
    normal(32'hC, 32'd4);
    // Redirect to 0x22 together with stall: PC becomes 0x20
    bubble(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'd8, 1'b0);
    normal(32'h20, 32'd9);
    // Redirect to 4 with flush, then flush alone at pc=4
    bubble(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'd1, 1'b0);
    bubble(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd2, 1'b0);
    normal(32'h8, 32'd3);
    // Stall plus flush: bubble, PC holds at 12
    bubble(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd3, 1'b0);
    normal(32'hC, 32'd4);
    // Reset mid-run wins over all controls; wrap instance returns to FFFF_FFFC
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA000_0000, 1'b1, 32'd1, 1'b0, 1'b1, WRAP_NEXT);
`ifndef FETCH_HALT_EN
    // Redirect with low bits set, then wrap from FFFF_FFFC to 0
    bubble(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h3FFF_FFFF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    normal(32'h0, 32'd1);
`else
    // Run off the end of an 18-word memory
    bubble(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
    for (int k = 0; k < 18; k++) normal(32'(4 * k), 32'(k + 1));
    bubble(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd18, 1'b1);
    bubble(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'd18, 1'b1);
    bubble(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd18, 1'b1);
    bubble(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
    normal(32'h0, 32'd1);
`endif
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core, sitting directly upstream of the instruction memory. It owns the program counter, drives the word address into the instruction memory, and latches the returned instruction with its PC into the IF/ID pipeline register. It applies stall, flush and branch/jump redirects from the hazard and execute logic.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address loaded into the PC on reset.
- `IMEM_DEPTH`, default 18: number of 32-bit words in the instruction memory; used only by the halt feature.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `stall`  input  1  hold the PC and IF/ID contents (load-use hazard).
- `flush`  input  1  load a bubble into IF/ID this cycle.
- `redirect`  input  1  taken branch or jump resolved downstream.
- `redirect_target`  input  32  byte address of the new PC.
- `imem_addr`  output  32  word index into the instruction memory, `pc >> 2`, combinational.
- `imem_instr`  input  32  instruction returned combinationally for `imem_addr`.
- `if_pc`  output  32  current PC (byte address).
- `id_pc`  output  32  IF/ID register: PC of the latched instruction.
- `id_instr`  output  32  IF/ID register: latched instruction.
- `id_valid`  output  1  IF/ID register holds a real instruction.
- `halted`  output  1  fetch has stopped (see Configuration).

## Operation
- State: `pc`[31:0], IF/ID register {`id_pc`, `id_instr`, `id_valid`}, `halted`.
- `imem_addr` = {2'b00, `pc`[31:2]}. `if_pc` = `pc`.
- A bubble is `id_pc`=0, `id_instr`=32'h0000_0013 (addi x0,x0,0), `id_valid`=0.
- Per-edge priority is reset > halted > redirect > stall > flush > normal.
  - Reset: `pc`=`RESET_PC`, IF/ID gets a bubble, `halted`=0.
  - Halted: all state holds. Redirect, stall and flush are ignored.
  - Redirect: `pc` = {`redirect_target`[31:2], 2'b00}. The low two bits are always forced to zero. IF/ID gets a bubble. Redirect overrides a simultaneous stall, because the stalled instruction is on the wrong path.
  - Stall without redirect: `pc` and IF/ID hold. A simultaneous `flush` still loads a bubble into IF/ID, and `pc` still holds.
  - Flush alone: IF/ID gets a bubble and `pc` = `pc`+4.
  - Normal: IF/ID gets {`pc`, `imem_instr`, 1} and `pc` = `pc`+4.
- PC arithmetic is 32-bit, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- The block has no internal combinational path from stall, flush or redirect to `imem_addr`. They affect only the next `pc`.

## Timing
- Reset values:
  - `pc` = `RESET_PC`, so `imem_addr` = `RESET_PC`>>2.
  - `id_pc` = 0, `id_instr` = 32'h13, `id_valid` = 0.
  - `halted` = 0.
- The first valid instruction appears on `id_*` one edge after reset deasserts.
- Fetch latency is one cycle: the instruction at `pc` in cycle N is on `id_instr` in cycle N+1.
- Redirect asserted in cycle N:
  - The target appears on `imem_addr` in cycle N+1.
  - The target's instruction is valid on `id_*` in cycle N+2.
  - `id_valid`=0 in cycle N+1.
- A stall held for K cycles freezes `id_*` and `imem_addr` for exactly K cycles.
- Reset asserted mid-stream takes effect at the next edge, regardless of stall, flush or redirect.

## Configuration
- Macro `FETCH_HALT_EN`.
  - Defined: on a normal-capture edge, if `pc`[31:2] >= `IMEM_DEPTH` or `imem_instr` == 32'h0000_0000:
    - The word is not captured, and IF/ID gets a bubble.
    - `pc` holds and `halted` becomes 1 on that edge.
    - Only reset clears `halted`.
    - Halt is not evaluated on stall, flush or redirect edges.
  - Not defined: `halted` is tied to 0. Out-of-range and all-zero words are captured like any other instruction.

## Test plan
- Reset release with `RESET_PC`=0 and the memory holding words W0..W3 -> `id_instr` shows W0, W1, W2 on successive cycles, with `id_pc` = 0, 4, 8 and `id_valid`=1.
- `stall` for 3 cycles while `pc`=8 -> `imem_addr` stays 2 and `id_*` frozen for 3 cycles; fetch resumes at 12.
- `redirect`=1 with `redirect_target`=32'h0000_0022, asserted together with `stall`=1 -> next `pc`=32'h20, `id_valid`=0 for one cycle, then `id_pc`=32'h20.
- `flush`=1 alone at `pc`=4 -> bubble with `id_instr`=32'h13, and `pc` advances to 8.
- `RESET_PC`=32'hFFFF_FFFC with no stalls -> `pc` wraps to 0 after one cycle; reset asserted mid-run -> `pc`=`RESET_PC` and `id_valid`=0 on the next edge.
- With `FETCH_HALT_EN` defined and `IMEM_DEPTH`=18, run straight-line code -> `halted`=1 after reaching `pc`=72, `pc` stays at 72, all subsequent `id_valid`=0, and only reset recovers.
